// File: rtl/mem_responder.sv
// Word-organised memory answering the multicycle datapath read/write handshake; optional macro MEM_RESPONDER_BOUNDS_CHECK_EN.
// Latency: LATENCY cycles from the request being sampled in IDLE to the one-cycle mem_resp pulse.
// Backpressure: none; a latched request always completes, and further requests are sampled only in IDLE.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_busy,
  output logic        mem_error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Counter preload so that WAIT lasts LATENCY-1 cycles before RESP.
  localparam int         CNT_INIT_INT = (LATENCY > 1) ? (LATENCY - 2) : 0;
  localparam logic [3:0] CNT_INIT     = CNT_INIT_INT[3:0];

  logic [31:0]           mem_q [2**ADDR_WIDTH];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  wr_q;
  logic                  oob_q;
  logic [31:0]           rdata_q;

  logic                  req_in;
  logic                  req_oob;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_oob;
  logic                  rd_is_read;
  logic                  load_rd;
  logic                  unused_addr_bits;

  assign req_in  = mem_read | mem_write;
  assign req_idx = mem_address[ADDR_WIDTH+1:2];

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
  assign req_oob = |mem_address[31:ADDR_WIDTH+2];
`else
  // Upper address bits alias: the memory wraps modulo its own size.
  assign req_oob = 1'b0;
`endif

  // Byte-offset bits never select anything; upper bits only matter with the bounds check.
  assign unused_addr_bits = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_in) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read source: with LATENCY == 1 the word is fetched on the sampling edge, so use the live request.
  always_comb begin
    rd_idx     = addr_q;
    rd_oob     = oob_q;
    rd_is_read = ~wr_q;
    if (state_q == IDLE) begin
      rd_idx     = req_idx;
      rd_oob     = req_oob;
      rd_is_read = mem_read & ~mem_write;
    end
    load_rd = (state_d == RESP) && (state_q != RESP) && rd_is_read;
  end

  // Control state, request latch and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      wr_q    <= 1'b0;
      oob_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_in) begin
        addr_q  <= req_idx;
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
        wr_q    <= mem_write;
        oob_q   <= req_oob;
      end
      if (load_rd) begin
        rdata_q <= rd_oob ? 32'hDEADBEEF : mem_q[rd_idx];
      end
    end
  end

  // Array commit on the edge leaving RESP; reset blocks it so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP && wr_q && !oob_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = (state_q == RESP);
  assign mem_busy  = (state_q == WAIT) || (state_q == RESP);
  assign mem_error = (state_q == RESP) && oob_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable word-organised memory that answers the RV32I multicycle datapath/control memory handshake (mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata in, mem_rdata/mem_resp out).
- Sits on the memory side of the MAR/MDR/MEM_DATA_OUT interface.
- Replaces the behavioural testbench memory for synthesis and standalone bring-up, with programmable response latency and byte-lane writes.

Parameters:
- ADDR_WIDTH, 10, number of word-index bits; the array holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 3, cycles from the request being sampled in IDLE to mem_resp high; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- mem_read  input  1  read request, held by the initiator until mem_resp.
- mem_write  input  1  write request, held by the initiator until mem_resp.
- mem_byte_enable  input  4  write lane enables; bit i covers mem_wdata[8i+7:8i].
- mem_address  input  32  byte address; bits [1:0] are ignored.
- mem_wdata  input  32  write data.
- mem_rdata  output  32  read data, registered.
- mem_resp  output  1  one-cycle completion pulse.
- mem_busy  output  1  high while a request is latched and not yet responded.
- mem_error  output  1  out-of-range flag, valid with mem_resp (see Optional Feature).

Behaviour:
- Reset (asynchronous, any cycle, including mid-request):
  - State goes to IDLE; counter = 0; mem_resp = 0, mem_busy = 0, mem_error = 0, mem_rdata = 32'h0.
  - Array contents are not cleared. Any in-flight write is dropped and the array is not modified.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_write or mem_read is sampled high: latch address word index (mem_address[ADDR_WIDTH+1:2]), wdata, byte enables and op.
  - mem_write has priority when both are high; the request is treated as a write.
  - If LATENCY == 1, go to RESP; otherwise go to WAIT with counter = LATENCY-2.
  - If neither is high, stay in IDLE.
- WAIT:
  - Decrement counter each cycle; when counter == 0, go to RESP.
  - All input changes are ignored; the latched request completes even if the initiator drops its request.
- RESP (exactly one cycle):
  - mem_resp = 1.
  - Read: mem_rdata shows the array word; it is loaded on the edge entering RESP and held until the next read response.
  - Write: lanes with byte_enable = 1 are updated on the edge leaving RESP. byte_enable = 4'b0000 still responds and leaves the array unchanged. mem_rdata is unchanged by writes.
  - Next state is always IDLE.
- Latency:
  - Request sampled high at edge N gives mem_resp high during cycle N+LATENCY.
  - If the initiator holds the request into the cycle after mem_resp, the request is sampled as a new request. Back-to-back throughput is one request per LATENCY+1 cycles.
- mem_busy = 1 in WAIT and RESP.
- Read-after-write to the same word in the next request returns the new data (the write is committed before IDLE samples).
- Address aliasing: upper address bits above ADDR_WIDTH+1 are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_RESPONDER_BOUNDS_CHECK_EN.
- When defined:
  - A request is out-of-range if any latched mem_address bit above ADDR_WIDTH+1 is set.
  - Out-of-range read: mem_rdata = 32'hDEADBEEF in RESP.
  - Out-of-range write: the array is not modified.
  - In both cases mem_error = 1 for the RESP cycle only. Latency is unchanged.
- When not defined: mem_error is tied 0 and addresses alias modulo 2**(ADDR_WIDTH+2) bytes.

Test Plan:
- Reset, then mem_read at 0x0000_0010 with LATENCY=3 -> mem_resp high exactly 3 cycles after sampling, for 1 cycle; mem_rdata = 0 (array preloaded zero by bench backdoor); mem_busy high for 3 cycles.
- Write 0xCAFEBABE, byte_enable 4'b1111, at 0x20; then write 0x000000FF, byte_enable 4'b0001, to 0x20; then read 0x20 -> 0xCAFEBAFF.
- mem_read and mem_write both high, address 0x40, wdata 0x12345678 -> treated as write; a subsequent read of 0x40 returns 0x12345678.
- Initiator drops mem_read one cycle after issue -> mem_resp still fires at LATENCY. Initiator holds mem_write one cycle past mem_resp -> a second write response follows LATENCY cycles later.
- Assert rst during WAIT of a write to 0x80 (old value 0x11111111) -> mem_resp = 0, mem_busy = 0, mem_rdata = 0 immediately; a later read of 0x80 returns 0x11111111.
- With MEM_RESPONDER_BOUNDS_CHECK_EN and ADDR_WIDTH=10: read 0x0000_1000 -> mem_rdata 0xDEADBEEF, mem_error = 1 with mem_resp. Without the macro, the same read returns the word at 0x0.
